// File: rtl/half_adder.sv
// half_adder: bit-wise half adder with a combinational result and a one-cycle
// registered copy qualified by a valid flag. Each lane is independent; there
// is no carry propagation between lanes.
//
// Ports:
//   clk       rising-edge clock for the registered path
//   rst_n     asynchronous active-low reset, clears s_q/c_q/out_valid
//   a, b      addends, one bit per lane
//   in_valid  qualifies a/b for capture into the registered path
//   s, c      combinational sum (a ^ b) and carry (a & b)
//   s_q, c_q  registered sum and carry, held while in_valid is low
//   out_valid registered in_valid, qualifies s_q/c_q
module half_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;

  // Lane-wise arithmetic; X on an input propagates rather than being masked.
  always_comb begin
    sum_d   = a ^ b;
    carry_d = a & b;
  end

  assign s = sum_d;
  assign c = carry_d;

  // The valid flag tracks in_valid every cycle; data only loads on valid so
  // the last result stays visible while the pipeline is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      c_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q <= sum_d;
        c_q <= carry_d;
      end
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder at WIDTH=1, 8 and 16.
module tb_half_adder;

  logic clk;
  logic rst_n;

  logic        a1, b1, v1;
  logic        s1, c1, sq1, cq1, ov1;
  logic [7:0]  a8, b8, s8, c8, sq8, cq8;
  logic        v8, ov8;
  logic [15:0] a16, b16, s16, c16, sq16, cq16;
  logic        v16, ov16;

  int total;
  int bad;

  half_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .s(s1), .c(c1), .s_q(sq1), .c_q(cq1), .out_valid(ov1)
  );

  half_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .s(s8), .c(c8), .s_q(sq8), .c_q(cq8), .out_valid(ov8)
  );

  half_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16),
    .s(s16), .c(c16), .s_q(sq16), .c_q(cq16), .out_valid(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    a8 = 8'hF0; b8 = 8'h0F; v8 = 1'b1;
    a16 = 16'h1234; b16 = 16'h00FF; v16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sq1, cq1, ov1} !== 3'b000) begin
      bad++;
      $display("FAIL reset_w1: got %b want 000", {sq1, cq1, ov1});
    end
    total++;
    if ({sq8, cq8, ov8} !== 17'h0) begin
      bad++;
      $display("FAIL reset_w8: got %h want 0", {sq8, cq8, ov8});
    end
    total++;
    if ({sq16, cq16, ov16} !== 33'h0) begin
      bad++;
      $display("FAIL reset_w16: got %h want 0", {sq16, cq16, ov16});
    end
    // Combinational path keeps working while in reset.
    total++;
    if ({s8, c8} !== {8'hFF, 8'h00}) begin
      bad++;
      $display("FAIL reset_comb_w8: got s=%h c=%h want s=ff c=00", s8, c8);
    end
    @(negedge clk);
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({sq1, cq1, ov1} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release_idle: got %b want 000", {sq1, cq1, ov1});
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] ab [4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] want [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      a1 = ab[i][1];
      b1 = ab[i][0];
      #2;
      total++;
      if ({s1, c1} !== want[i]) begin
        bad++;
        $display("FAIL truth_table ab=%b: got sc=%b want %b", ab[i], {s1, c1}, want[i]);
      end
    end
  endtask

  task automatic test_registered_w1();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({sq1, cq1, ov1} !== 3'b011) begin
      bad++;
      $display("FAIL reg_w1_valid: got sq,cq,ov=%b want 011", {sq1, cq1, ov1});
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({sq1, cq1, ov1} !== 3'b010) begin
      bad++;
      $display("FAIL reg_w1_hold: got sq,cq,ov=%b want 010", {sq1, cq1, ov1});
    end
  endtask

  task automatic test_w8_pattern();
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    #1;
    total++;
    if ({s8, c8} !== {8'hCC, 8'h30}) begin
      bad++;
      $display("FAIL w8_comb: got s=%h c=%h want s=cc c=30", s8, c8);
    end
    total++;
    if (ov8 !== 1'b0) begin
      bad++;
      $display("FAIL w8_latency: out_valid=%b before edge, want 0", ov8);
    end
    @(posedge clk);
    #1;
    total++;
    if ({sq8, cq8, ov8} !== {8'hCC, 8'h30, 1'b1}) begin
      bad++;
      $display("FAIL w8_reg: got sq=%h cq=%h ov=%b want cc 30 1", sq8, cq8, ov8);
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h00, 8'hFF, 8'hAA};
    logic [7:0] vb [3] = '{8'hFF, 8'hFF, 8'h55};
    logic [7:0] ws [3] = '{8'hFF, 8'h00, 8'hFF};
    logic [7:0] wc [3] = '{8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; v8 = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({sq8, cq8, ov8} !== {ws[i], wc[i], 1'b1}) begin
        bad++;
        $display("FAIL b2b[%0d]: got sq=%h cq=%h ov=%b want %h %h 1",
                 i, sq8, cq8, ov8, ws[i], wc[i]);
      end
    end
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk);
    #1;
    total++;
    if ({sq8, cq8, ov8} !== {8'hFF, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL b2b_drain: got sq=%h cq=%h ov=%b want ff 00 0", sq8, cq8, ov8);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0A; v8 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({sq8, cq8, ov8} !== {8'h05, 8'h0A, 1'b1}) begin
      bad++;
      $display("FAIL arst_pre: got sq=%h cq=%h ov=%b want 05 0a 1", sq8, cq8, ov8);
    end
    // Assert reset between edges; registers must clear without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({sq8, cq8, ov8} !== 17'h0) begin
      bad++;
      $display("FAIL arst_clear: got sq=%h cq=%h ov=%b want 0 0 0", sq8, cq8, ov8);
    end
    a8 = 8'hC3; b8 = 8'h81;
    #1;
    total++;
    if ({s8, c8} !== {8'h42, 8'h81}) begin
      bad++;
      $display("FAIL arst_comb: got s=%h c=%h want 42 81", s8, c8);
    end
    @(posedge clk);
    #1;
    total++;
    if ({sq8, cq8, ov8} !== 17'h0) begin
      bad++;
      $display("FAIL arst_hold: got sq=%h cq=%h ov=%b want 0 0 0", sq8, cq8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({sq8, cq8, ov8} !== {8'h42, 8'h81, 1'b1}) begin
      bad++;
      $display("FAIL arst_first_capture: got sq=%h cq=%h ov=%b want 42 81 1", sq8, cq8, ov8);
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] esq16, ecq16;
    logic        eov16, esq1, ecq1, eov1;
    int          errs;
    errs  = 0;
    esq16 = sq16; ecq16 = cq16; eov16 = ov16;
    esq1  = sq1;  ecq1  = cq1;  eov1  = ov1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'($urandom);
      #1;
      if ({s16, c16, s1, c1} !== {a16 ^ b16, a16 & b16, a1 ^ b1, a1 & b1}) errs++;
      if (v16) begin esq16 = a16 ^ b16; ecq16 = a16 & b16; end
      eov16 = v16;
      if (v1) begin esq1 = a1 ^ b1; ecq1 = a1 & b1; end
      eov1 = v1;
      @(posedge clk);
      #1;
      if ({sq16, cq16, ov16} !== {esq16, ecq16, eov16}) errs++;
      if ({sq1, cq1, ov1} !== {esq1, ecq1, eov1}) errs++;
      if (ov16 && ((sq16 & cq16) !== 16'h0)) errs++;
      if (ov1 && ((sq1 & cq1) !== 1'b0)) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL random: got %0d mismatching checks want 0", errs);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_truth_table();
    test_registered_w1();
    test_w8_pattern();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
